id_ex_stage: RTL

//  ID/EX pipeline register plus EX-stage operand/ALU-control generation.

---
 rtl/id_ex_stage_if.sv | 42 ++++
 rtl/id_ex_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// Bundles the decode-side fields, forwarding taps and EX-stage operand outputs of id_ex_stage.
interface id_ex_stage_if;
  logic        stall;
  logic        flush;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [15:0] id_imm;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_valid;
  logic        ex_illegal;

  modport master (
    output stall, flush, id_opcode, id_funct, id_rs, id_rt, id_rd, id_shamt, id_imm,
           id_rs_val, id_rt_val, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  alu_a, alu_b, alu_op, ex_store_data, ex_dest, ex_reg_write, ex_valid, ex_illegal
  );

  modport slave (
    input  stall, flush, id_opcode, id_funct, id_rs, id_rt, id_rd, id_shamt, id_imm,
           id_rs_val, id_rt_val, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output alu_a, alu_b, alu_op, ex_store_data, ex_dest, ex_reg_write, ex_valid, ex_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes at latch time, then builds ALU operands with
// EX/MEM and MEM/WB forwarding applied combinationally in the EX stage.
module id_ex_stage (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  typedef enum logic [1:0] {ASelRs, ASelShamt, ASel16} a_sel_e;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluNor  = 4'd5;
  localparam logic [3:0] AluSll  = 4'd6;
  localparam logic [3:0] AluSrl  = 4'd7;
  localparam logic [3:0] AluSra  = 4'd8;
  localparam logic [3:0] AluSlt  = 4'd9;
  localparam logic [3:0] AluSltu = 4'd10;

  logic        valid_q, valid_d;
  logic        illegal_q, illegal_d;
  logic        reg_write_q, reg_write_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [4:0]  dest_q, dest_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [31:0] rs_val_q, rs_val_d;
  logic [31:0] rt_val_q, rt_val_d;
  logic [31:0] imm_q, imm_d;
  logic        b_imm_q, b_imm_d;
  a_sel_e      a_sel_q, a_sel_d;

  logic [31:0] imm_sext, imm_zext;
  logic [3:0]  dec_op;
  a_sel_e      dec_a_sel;
  logic        dec_b_imm;
  logic [31:0] dec_imm;
  logic [4:0]  dec_dest;
  logic        dec_reg_write;
  logic        dec_illegal;
  logic [31:0] rs_fwd, rt_fwd;

  // Decode of the instruction currently presented by ID.
  always_comb begin
    imm_sext      = {{16{bus.id_imm[15]}}, bus.id_imm};
    imm_zext      = {16'h0000, bus.id_imm};
    dec_op        = AluAdd;
    dec_a_sel     = ASelRs;
    dec_b_imm     = 1'b0;
    dec_imm       = imm_sext;
    dec_dest      = bus.id_rt;
    dec_reg_write = 1'b1;
    dec_illegal   = 1'b0;
    if (bus.id_opcode == 6'h00) begin
      dec_dest = bus.id_rd;
      case (bus.id_funct)
        6'h20, 6'h21: dec_op = AluAdd;
        6'h22, 6'h23: dec_op = AluSub;
        6'h24:        dec_op = AluAnd;
        6'h25:        dec_op = AluOr;
        6'h26:        dec_op = AluXor;
        6'h27:        dec_op = AluNor;
        6'h2A:        dec_op = AluSlt;
        6'h2B:        dec_op = AluSltu;
        6'h00: begin dec_op = AluSll; dec_a_sel = ASelShamt; end
        6'h02: begin dec_op = AluSrl; dec_a_sel = ASelShamt; end
        6'h03: begin dec_op = AluSra; dec_a_sel = ASelShamt; end
        6'h04:        dec_op = AluSll;
        6'h06:        dec_op = AluSrl;
        6'h07:        dec_op = AluSra;
        default: begin
          dec_reg_write = 1'b0;
          dec_illegal   = 1'b1;
        end
      endcase
    end else begin
      dec_b_imm = 1'b1;
      case (bus.id_opcode)
        6'h08, 6'h09, 6'h23: dec_op = AluAdd;
        6'h0A: dec_op = AluSlt;
        6'h0B: dec_op = AluSltu;
        6'h0C: begin dec_op = AluAnd; dec_imm = imm_zext; end
        6'h0D: begin dec_op = AluOr;  dec_imm = imm_zext; end
        6'h0E: begin dec_op = AluXor; dec_imm = imm_zext; end
        6'h2B: dec_reg_write = 1'b0;
        // lui is executed as imm << 16 on the shifter.
        6'h0F: begin dec_op = AluSll; dec_a_sel = ASel16; dec_imm = imm_zext; end
        default: begin
          dec_b_imm     = 1'b0;
          dec_reg_write = 1'b0;
          dec_illegal   = 1'b1;
        end
      endcase
    end
  end

  function automatic logic [31:0] fwd(logic [4:0] src, logic [31:0] val,
                                      logic ex_we, logic [4:0] ex_rd, logic [31:0] ex_res,
                                      logic wb_we, logic [4:0] wb_rd, logic [31:0] wb_res);
    if (ex_we && (ex_rd == src) && (src != 5'd0)) return ex_res;
    if (wb_we && (wb_rd == src) && (src != 5'd0)) return wb_res;
    return val;
  endfunction

  always_comb begin
    rs_fwd = fwd(rs_q, rs_val_q, bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                 bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
    rt_fwd = fwd(rt_q, rt_val_q, bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                 bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
  end

  always_comb begin
    valid_d     = valid_q;
    illegal_d   = illegal_q;
    reg_write_d = reg_write_q;
    alu_op_d    = alu_op_q;
    dest_d      = dest_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    shamt_d     = shamt_q;
    imm_d       = imm_q;
    b_imm_d     = b_imm_q;
    a_sel_d     = a_sel_q;
    // While stalled, capture forwarded values so a producer retiring now is not lost.
    rs_val_d    = rs_fwd;
    rt_val_d    = rt_fwd;
    if (bus.flush) begin
      valid_d     = 1'b0;
      illegal_d   = 1'b0;
      reg_write_d = 1'b0;
      alu_op_d    = AluAdd;
      dest_d      = 5'd0;
      rs_d        = 5'd0;
      rt_d        = 5'd0;
      shamt_d     = 5'd0;
      imm_d       = 32'd0;
      b_imm_d     = 1'b0;
      a_sel_d     = ASelRs;
      rs_val_d    = 32'd0;
      rt_val_d    = 32'd0;
    end else if (!bus.stall) begin
      valid_d     = 1'b1;
      illegal_d   = dec_illegal;
      reg_write_d = dec_reg_write;
      alu_op_d    = dec_op;
      dest_d      = dec_dest;
      rs_d        = bus.id_rs;
      rt_d        = bus.id_rt;
      shamt_d     = bus.id_shamt;
      imm_d       = dec_imm;
      b_imm_d     = dec_b_imm;
      a_sel_d     = dec_a_sel;
      rs_val_d    = bus.id_rs_val;
      rt_val_d    = bus.id_rt_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      illegal_q   <= 1'b0;
      reg_write_q <= 1'b0;
      alu_op_q    <= AluAdd;
      dest_q      <= 5'd0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      shamt_q     <= 5'd0;
      imm_q       <= 32'd0;
      b_imm_q     <= 1'b0;
      a_sel_q     <= ASelRs;
      rs_val_q    <= 32'd0;
      rt_val_q    <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      illegal_q   <= illegal_d;
      reg_write_q <= reg_write_d;
      alu_op_q    <= alu_op_d;
      dest_q      <= dest_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      shamt_q     <= shamt_d;
      imm_q       <= imm_d;
      b_imm_q     <= b_imm_d;
      a_sel_q     <= a_sel_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
    end
  end

  always_comb begin
    case (a_sel_q)
      ASelShamt: bus.alu_a = {27'd0, shamt_q};
      ASel16:    bus.alu_a = 32'd16;
      default:   bus.alu_a = rs_fwd;
    endcase
    bus.alu_b         = b_imm_q ? imm_q : rt_fwd;
    bus.alu_op        = alu_op_q;
    bus.ex_store_data = rt_fwd;
    bus.ex_dest       = dest_q;
    bus.ex_reg_write  = reg_write_q;
    bus.ex_valid      = valid_q;
    bus.ex_illegal    = illegal_q;
  end

endmodule
